// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian words into instruction memory.
// Optional trailer XOR check enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int MEM_SIZE   = 512,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            RxData,
    input  logic                  RxValid,
    output logic                  RxReady,
    output logic                  MemWrite,
    output logic [31:0]           MemAddress,
    output logic [31:0]           MemWriteData,
    output logic                  CpuHold,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [ADDR_WIDTH:0]   WordCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        S_CHECK
`endif
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MEM_SIZE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_FIN = S_CHECK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t              state;
    state_t              state_n;
    logic [7:0]          len_hi;
    logic [15:0]         len;
    logic [1:0]          byte_cnt;
    logic [23:0]         shift;
    logic [ADDR_WIDTH:0] word_cnt;
    logic [ADDR_WIDTH:0] word_inc;
    logic [15:0]         len_n;
    logic                accept;
    logic                start_ok;
    logic                more;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign accept   = RxValid && RxReady;
    assign start_ok = Start && !Busy;
    assign len_n    = {len_hi, RxData};
    assign word_inc = word_cnt + 1'b1;
    assign more     = 16'(word_inc) < len;

    // Every control output decodes from state alone, so RxReady never depends on RxValid.
    always_comb begin
        RxReady  = 1'b0;
        MemWrite = 1'b0;
        Busy     = 1'b1;
        Done     = 1'b0;
        Error    = 1'b0;
        CpuHold  = 1'b1;
        unique case (state)
            S_IDLE:   Busy = 1'b0;
            S_LEN_HI: RxReady = 1'b1;
            S_LEN_LO: RxReady = 1'b1;
            S_DATA:   RxReady = 1'b1;
            S_WRITE:  MemWrite = 1'b1;
            S_DONE: begin
                Busy    = 1'b0;
                Done    = 1'b1;
                CpuHold = 1'b0;
            end
            S_ERROR: begin
                Busy  = 1'b0;
                Error = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK:  RxReady = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Start) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (len_n > MAX_LEN)    state_n = S_ERROR;
                    else if (len_n == 16'd0) state_n = S_FIN;
                    else                     state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (accept && byte_cnt == 2'd3) state_n = S_WRITE;
            end
            S_WRITE: state_n = more ? S_DATA : S_FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) state_n = (RxData == csum) ? S_DONE : S_ERROR;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            len_hi       <= '0;
            len          <= '0;
            byte_cnt     <= '0;
            shift        <= '0;
            word_cnt     <= '0;
            MemAddress   <= '0;
            MemWriteData <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state <= state_n;
            if (start_ok) begin
                word_cnt <= '0;
                byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (state == S_LEN_HI && accept) len_hi <= RxData;
            if (state == S_LEN_LO && accept) len <= len_n;
            if (state == S_DATA && accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= {shift[15:0], RxData};
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= csum ^ RxData;
`endif
                // Address/data are latched once so they hold after the strobe drops.
                if (byte_cnt == 2'd3) begin
                    MemAddress   <= 32'({word_cnt, 2'b00});
                    MemWriteData <= {shift, RxData};
                end
            end
            if (state == S_WRITE) word_cnt <= word_inc;
        end
    end

    assign WordCount = word_cnt;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued by stimulus, popped by a monitor.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  RxData = 8'h00;
    logic        RxValid = 1'b0;
    logic        RxReady;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        CpuHold;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [9:0]  WordCount;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  xacc;

    imem_loader dut (
        .clk(clk), .reset(reset), .Start(Start),
        .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
        .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemWriteData(MemWriteData), .CpuHold(CpuHold),
        .Busy(Busy), .Done(Done), .Error(Error),
        .WordCount(WordCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset && MemWrite) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h", MemAddress, MemWriteData);
            end else begin
                chk("wr_addr", MemAddress, exp_addr.pop_front());
                chk("wr_data", MemWriteData, exp_data.pop_front());
            end
            chk("wr_rxready", 32'(RxReady), 32'd0);
        end
    end

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        xacc = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int  guard;
        bit  acc;
        guard = 0;
        acc = 1'b0;
        RxData = b;
        while (!acc && guard < 200) begin
            guard++;
            if (rnd && $urandom_range(0, 1) == 0) begin
                RxValid = 1'b0;
                @(posedge clk); #1;
            end else begin
                RxValid = 1'b1;
                acc = RxReady;
                @(posedge clk); #1;
            end
        end
        RxValid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte %h not accepted", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit rnd);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            xacc = xacc ^ v[31:24];
            send_byte(v[31:24], rnd);
            v = v << 8;
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(Done || Error) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: Done %b Error %b", Done, Error);
        end
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(xacc, 1'b0);
`endif
        wait_end();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hold"}, 32'(CpuHold), 32'd1);
        chk({tag, "_ready"}, 32'(RxReady), 32'd0);
        chk({tag, "_mw"}, 32'(MemWrite), 32'd0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_done"}, 32'(Done), 32'd0);
        chk({tag, "_err"}, 32'(Error), 32'd0);
        chk({tag, "_addr"}, MemAddress, 32'd0);
        chk({tag, "_data"}, MemWriteData, 32'd0);
        chk({tag, "_wc"}, 32'(WordCount), 32'd0);
    endtask

    initial begin
        xacc = 8'h00;
        #2;
        chk_reset_vals("rst");
        #10 reset = 1'b1;

        // Two-word load, RxValid held high
        pulse_start();
        chk("start_ready", 32'(RxReady), 32'd1);
        chk("start_busy", 32'(Busy), 32'd1);
        chk("start_hold", 32'(CpuHold), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        expect_wr(32'h0, 32'h20040074);
        expect_wr(32'h4, 32'h20050000);
        send_word(32'h20040074, 1'b0);
        send_word(32'h20050000, 1'b0);
        chk("w2_mw", 32'(MemWrite), 32'd1);
        chk("w2_ready", 32'(RxReady), 32'd0);
        chk("w2_addr", MemAddress, 32'h4);
`ifndef IMEM_LOADER_CHECKSUM_EN
        @(posedge clk); #1;
        chk("w2_done_edge", 32'(Done), 32'd1);
`endif
        finish_load();
        chk("t1_wc", 32'(WordCount), 32'd2);
        chk("t1_done", 32'(Done), 32'd1);
        chk("t1_hold", 32'(CpuHold), 32'd0);
        chk("t1_err", 32'(Error), 32'd0);
        @(posedge clk); #1;
        chk("t1_addr_hold", MemAddress, 32'h4);
        chk("t1_data_hold", MemWriteData, 32'h20050000);

        // Oversize header 0x0201
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("big_err", 32'(Error), 32'd1);
        chk("big_hold", 32'(CpuHold), 32'd1);
        chk("big_busy", 32'(Busy), 32'd0);
        chk("big_ready", 32'(RxReady), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("big_err_stay", 32'(Error), 32'd1);

        // Empty image
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("n0_busy", 32'(Busy), 32'd1);
        send_byte(8'h00, 1'b0);
        chk("n0_done", 32'(Done), 32'd1);
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        chk("n0_bad_err", 32'(Error), 32'd1);
`else
        chk("n0_done", 32'(Done), 32'd1);
        chk("n0_hold", 32'(CpuHold), 32'd0);
`endif
        chk("n0_wc", 32'(WordCount), 32'd0);

        // Three words with random RxValid gaps
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        expect_wr(32'h0, 32'h11223344);
        expect_wr(32'h4, 32'h55667788);
        expect_wr(32'h8, 32'h99AABBCC);
        send_word(32'h11223344, 1'b1);
        send_word(32'h55667788, 1'b1);
        send_word(32'h99AABBCC, 1'b1);
        finish_load();
        chk("rnd_wc", 32'(WordCount), 32'd3);
        chk("rnd_done", 32'(Done), 32'd1);

        // Reset mid-load after 6 data bytes
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h04, 1'b0);
        expect_wr(32'h0, 32'hA1A2A3A4);
        send_word(32'hA1A2A3A4, 1'b0);
        send_byte(8'hB1, 1'b0);
        send_byte(8'hB2, 1'b0);
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        #1 reset = 1'b1;
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        expect_wr(32'h0, 32'hC0FFEE01);
        send_word(32'hC0FFEE01, 1'b0);
        finish_load();
        chk("rl_wc", 32'(WordCount), 32'd1);
        chk("rl_done", 32'(Done), 32'd1);

        // Start during DATA is ignored; Start in DONE restarts
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'hAD, 1'b0);
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
        chk("ign_busy", 32'(Busy), 32'd1);
        chk("ign_ready", 32'(RxReady), 32'd1);
        expect_wr(32'h0, 32'hDEADBEEF);
        xacc = 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
        send_byte(8'hBE, 1'b0);
        send_byte(8'hEF, 1'b0);
        finish_load();
        chk("ign_wc", 32'(WordCount), 32'd1);
        chk("ign_done", 32'(Done), 32'd1);
        pulse_start();
        chk("re_hold", 32'(CpuHold), 32'd1);
        chk("re_done", 32'(Done), 32'd0);
        chk("re_busy", 32'(Busy), 32'd1);
        chk("re_wc", 32'(WordCount), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(exp_addr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
